foc_period_sched: RTL
=====================

# foc_period_sched

Per-PWM-period scheduler for the FOC loop. It watches the SVPWM triangle counter and fires the current-sense ADC at each counter valley. It then runs the FOC compute chain (Clarke/Park/PI/inverse-Park) and commits the resulting polar voltage command to the SVPWM's `v_ph_i`/`v_mag_i` before the SVPWM latches them on the down-count. It also owns start-up shunt-offset calibration: PWM is held off and 2^CAL_LOG2 ADC samples are averaged into per-phase offsets.

## Interface
Parameters:
- `CAL_LOG2`, default 6: log2 of the calibration sample count (64 samples).
- `DEADLINE`, default 24: down-count counter value at which the period's result must be committed. Must be greater than 20, the SVPWM latch point.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; level sensitive.
- `pwm_cnt` in 11: SVPWM triangle counter, range 0..1024.
- `pwm_dir` in 1: SVPWM count direction; 1 = up, 0 = down.
- `adc_start` out 1: one-cycle pulse that starts an ADC conversion.
- `adc_done` in 1: one-cycle pulse; `adc_ia`/`adc_ib` are valid in the same cycle.
- `adc_ia`, `adc_ib` in 12: unsigned raw phase-current samples.
- `foc_start` out 1: one-cycle pulse that starts the compute chain.
- `foc_done` in 1: one-cycle pulse; `foc_v_ph`/`foc_v_mag` are valid in the same cycle.
- `foc_v_ph`, `foc_v_mag` in 16: compute-chain result.
- `ia_o`, `ib_o` out 16 signed: offset-corrected currents, fed to the compute chain.
- `v_ph_o`, `v_mag_o` out 16: committed command, connected to SVPWM `v_ph_i`/`v_mag_i`.
- `pwm_en` out 1: connected to SVPWM `pwm_en`.
- `cal_done` out 1: offsets are valid.
- `overrun` out 1: one-cycle pulse when a deadline is missed.
- `overrun_cnt` out 8: saturating count of missed deadlines.

## Operation
- **Valley event:** `pwm_cnt == 0`. **Deadline event:** `pwm_dir == 0 && pwm_cnt == DEADLINE`.
- **States:** IDLE, CAL_WAIT, CAL_ADC, RUN_WAIT, RUN_ADC, RUN_FOC.
- **IDLE**
  - `pwm_en` = 0; `cal_done` = 0; the accumulators and sample counter are cleared.
  - Goes to CAL_WAIT when `enable` = 1.
- **CAL_WAIT**
  - On a valley: pulse `adc_start`, then go to CAL_ADC.
- **CAL_ADC**
  - On `adc_done`: add the samples into `acc_a`/`acc_b` (each 12+CAL_LOG2 bits) and increment the sample counter.
  - After the 2^CAL_LOG2-th sample: `off_a = acc_a >> CAL_LOG2` (same for `off_b`), set `cal_done` = 1 and `pwm_en` = 1, then go to RUN_WAIT.
  - Otherwise return to CAL_WAIT.
  - Valleys that arrive while waiting here are ignored. Calibration has no deadline.
- **RUN_WAIT**
  - On a valley: pulse `adc_start`, then go to RUN_ADC.
- **RUN_ADC**
  - On `adc_done`:
    - `ia_o = {4'b0, adc_ia} - {4'b0, off_a}`, 16-bit two's complement, range -4095..4095; `ib_o` likewise.
    - Pulse `foc_start`, then go to RUN_FOC.
- **RUN_FOC**
  - On `foc_done`: load `v_ph_o`/`v_mag_o` from `foc_v_ph`/`foc_v_mag`, then go to RUN_WAIT.
- **Deadline miss** (deadline event while in RUN_ADC or RUN_FOC):
  - Pulse `overrun`; `overrun_cnt` += 1, saturating at 255.
  - `v_ph_o`/`v_mag_o` and `ia_o`/`ib_o` hold their previous values.
  - Go to RUN_WAIT.
- **Simultaneous deadline and done** in the same cycle: the deadline wins. This counts as an overrun and the done is discarded.
- **Stray pulses:** `adc_done`/`foc_done` arriving in any state other than the one waiting for it are ignored. This covers late dones after an abort.
- **`enable` deasserted** in any state: go to IDLE on the next edge; `pwm_en` and `cal_done` go to 0. Any operation in flight is abandoned. Re-enabling re-runs the full calibration.
- **`overrun_cnt`** is cleared only by `rst_n`.

## Timing
- **Reset values:**
  - All outputs are 0: `adc_start`, `foc_start`, `ia_o`, `ib_o`, `v_ph_o`, `v_mag_o`, `pwm_en`, `cal_done`, `overrun`, `overrun_cnt`.
  - `off_a`/`off_b` are 0; the state is IDLE.
- **Latencies** (all outputs registered):
  - `adc_start` is asserted the cycle after the valley cycle.
  - `ia_o`/`ib_o` and `foc_start` are asserted the cycle after `adc_done`.
  - `v_ph_o`/`v_mag_o` update the cycle after `foc_done`.
  - `overrun` is asserted the cycle after the deadline cycle.
  - `cal_done`/`pwm_en` rise the cycle after the final calibration `adc_done`.
- **Available window:** the valley is at 0. The deadline on the down-count is 2048 − DEADLINE cycles later (2024 by default). That window covers ADC plus compute.
- **Stable latch window:** commits happen only between a valley and its deadline. `v_ph_o`/`v_mag_o` are therefore stable over down-counts DEADLINE..0, which includes the SVPWM latch at 20/19.

## Test plan
1. **Reset:** assert `rst_n` = 0 mid-RUN_FOC → all outputs read 0 immediately. After release with `enable` = 0, the block stays in IDLE with `pwm_en` = 0.
2. **Calibration:** `enable` = 1; the ADC returns ia = 2048, ib = 2050 for 64 valleys.
   - `cal_done` and `pwm_en` rise the cycle after the 64th `adc_done`.
   - Next valley with ia = 2100, ib = 2000 → `ia_o` = 52, `ib_o` = −50 (0xFFCE).
3. **Normal period:** `foc_done` arrives 100 cycles after `foc_start` with ph = 0x4000, mag = 0x2000.
   - `v_ph_o` = 0x4000 and `v_mag_o` = 0x2000 one cycle later; no `overrun`.
   - `adc_start` fires exactly once per 2048 cycles.
4. **Overrun:** withhold `foc_done` past down-count 24.
   - `overrun` pulses and `overrun_cnt` = 1; the outputs keep their prior values.
   - A late `foc_done` is ignored; the next period completes normally.
   - Also drive `foc_done` in the same cycle as the deadline → counted as an overrun, and no commit occurs.
5. **Saturation:** force 300 consecutive overruns → `overrun_cnt` stops at 255.
6. **Enable drop:** drop `enable` during RUN_ADC.
   - `pwm_en` and `cal_done` are 0 next cycle; a subsequent `adc_done` has no effect.
   - Re-enabling takes 64 new calibration samples before `pwm_en` = 1.

Source files
------------

// File: rtl/foc_period_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | foc_period_sched                                                         |
// | Per-PWM-period ADC/FOC scheduler with start-up shunt-offset calibration. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module foc_period_sched #(
  parameter int CAL_LOG2 = 6,
  parameter int DEADLINE = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [10:0]        pwm_cnt,
  input  logic               pwm_dir,
  output logic               adc_start,
  input  logic               adc_done,
  input  logic [11:0]        adc_ia,
  input  logic [11:0]        adc_ib,
  output logic               foc_start,
  input  logic               foc_done,
  input  logic [15:0]        foc_v_ph,
  input  logic [15:0]        foc_v_mag,
  output logic signed [15:0] ia_o,
  output logic signed [15:0] ib_o,
  output logic [15:0]        v_ph_o,
  output logic [15:0]        v_mag_o,
  output logic               pwm_en,
  output logic               cal_done,
  output logic               overrun,
  output logic [7:0]         overrun_cnt
);

  localparam int          c_ACC_W    = 12 + CAL_LOG2;
  localparam logic [10:0] c_DEADLINE = 11'(DEADLINE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CAL_WAIT = 3'd1,
    S_CAL_ADC  = 3'd2,
    S_RUN_WAIT = 3'd3,
    S_RUN_ADC  = 3'd4,
    S_RUN_FOC  = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [c_ACC_W-1:0]  r_acc_a, r_acc_b, w_acc_a_nxt, w_acc_b_nxt;
  logic [c_ACC_W-1:0]  w_acc_a_sum, w_acc_b_sum;
  logic [CAL_LOG2-1:0] r_smp_cnt, w_smp_cnt_nxt;
  logic [11:0]         r_off_a, r_off_b, w_off_a_nxt, w_off_b_nxt;
  logic signed [15:0]  w_ia_nxt, w_ib_nxt;
  logic [15:0]         w_v_ph_nxt, w_v_mag_nxt;
  logic                w_adc_start_nxt, w_foc_start_nxt, w_pwm_en_nxt, w_cal_done_nxt;
  logic                w_miss;
  logic [7:0]          w_overrun_cnt_nxt;
  logic                w_valley, w_deadline;

  assign w_valley    = (pwm_cnt == 11'd0);
  assign w_deadline  = !pwm_dir && (pwm_cnt == c_DEADLINE);
  assign w_acc_a_sum = r_acc_a + {{CAL_LOG2{1'b0}}, adc_ia};
  assign w_acc_b_sum = r_acc_b + {{CAL_LOG2{1'b0}}, adc_ib};

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_a_nxt     = r_acc_a;
    w_acc_b_nxt     = r_acc_b;
    w_smp_cnt_nxt   = r_smp_cnt;
    w_off_a_nxt     = r_off_a;
    w_off_b_nxt     = r_off_b;
    w_ia_nxt        = ia_o;
    w_ib_nxt        = ib_o;
    w_v_ph_nxt      = v_ph_o;
    w_v_mag_nxt     = v_mag_o;
    w_adc_start_nxt = 1'b0;
    w_foc_start_nxt = 1'b0;
    w_pwm_en_nxt    = pwm_en;
    w_cal_done_nxt  = cal_done;
    w_miss          = 1'b0;

    if (!enable) begin
      w_state_nxt    = S_IDLE;
      w_pwm_en_nxt   = 1'b0;
      w_cal_done_nxt = 1'b0;
      w_acc_a_nxt    = '0;
      w_acc_b_nxt    = '0;
      w_smp_cnt_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_acc_a_nxt   = '0;
          w_acc_b_nxt   = '0;
          w_smp_cnt_nxt = '0;
          w_state_nxt   = S_CAL_WAIT;
        end
        S_CAL_WAIT: begin
          if (w_valley) begin
            w_adc_start_nxt = 1'b1;
            w_state_nxt     = S_CAL_ADC;
          end
        end
        S_CAL_ADC: begin
          if (adc_done) begin
            w_acc_a_nxt   = w_acc_a_sum;
            w_acc_b_nxt   = w_acc_b_sum;
            w_smp_cnt_nxt = r_smp_cnt + CAL_LOG2'(1);
            // Counter at all-ones means this is the final sample of the batch.
            if (&r_smp_cnt) begin
              w_off_a_nxt    = w_acc_a_sum[c_ACC_W-1:CAL_LOG2];
              w_off_b_nxt    = w_acc_b_sum[c_ACC_W-1:CAL_LOG2];
              w_cal_done_nxt = 1'b1;
              w_pwm_en_nxt   = 1'b1;
              w_state_nxt    = S_RUN_WAIT;
            end else begin
              w_state_nxt = S_CAL_WAIT;
            end
          end
        end
        S_RUN_WAIT: begin
          if (w_valley) begin
            w_adc_start_nxt = 1'b1;
            w_state_nxt     = S_RUN_ADC;
          end
        end
        S_RUN_ADC: begin
          if (w_deadline) begin
            w_miss = 1'b1;
          end else if (adc_done) begin
            w_ia_nxt        = {4'b0, adc_ia} - {4'b0, r_off_a};
            w_ib_nxt        = {4'b0, adc_ib} - {4'b0, r_off_b};
            w_foc_start_nxt = 1'b1;
            w_state_nxt     = S_RUN_FOC;
          end
        end
        S_RUN_FOC: begin
          if (w_deadline) begin
            w_miss = 1'b1;
          end else if (foc_done) begin
            w_v_ph_nxt  = foc_v_ph;
            w_v_mag_nxt = foc_v_mag;
            w_state_nxt = S_RUN_WAIT;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
      if (w_miss) begin
        w_state_nxt = S_RUN_WAIT;
      end
    end
  end

  assign w_overrun_cnt_nxt = (w_miss && (overrun_cnt != 8'hFF)) ? overrun_cnt + 8'd1
                                                                  : overrun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_acc_a     <= '0;
      r_acc_b     <= '0;
      r_smp_cnt   <= '0;
      r_off_a     <= '0;
      r_off_b     <= '0;
      ia_o        <= '0;
      ib_o        <= '0;
      v_ph_o      <= '0;
      v_mag_o     <= '0;
      adc_start   <= 1'b0;
      foc_start   <= 1'b0;
      pwm_en      <= 1'b0;
      cal_done    <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_a     <= w_acc_a_nxt;
      r_acc_b     <= w_acc_b_nxt;
      r_smp_cnt   <= w_smp_cnt_nxt;
      r_off_a     <= w_off_a_nxt;
      r_off_b     <= w_off_b_nxt;
      ia_o        <= w_ia_nxt;
      ib_o        <= w_ib_nxt;
      v_ph_o      <= w_v_ph_nxt;
      v_mag_o     <= w_v_mag_nxt;
      adc_start   <= w_adc_start_nxt;
      foc_start   <= w_foc_start_nxt;
      pwm_en      <= w_pwm_en_nxt;
      cal_done    <= w_cal_done_nxt;
      overrun     <= w_miss;
      overrun_cnt <= w_overrun_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
